mul_alu_seq: RTL and testbench

//  Multi-cycle unsigned 32x32->64 multiplier sequencer for the EX stage. Owns no adder:

---
 rtl/mul_alu_seq.sv | 121 ++++++++++++
 tb/tb_mul_alu_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_alu_seq.sv
// Multi-cycle unsigned 32x32->64 shift-add multiplier that borrows the shared EX-stage ALU
// for its additions; the pipeline stalls EX while busy is high.
module mul_alu_seq #(
  parameter int          XLEN    = 32,
  parameter int          CNT_W   = 6,
  parameter logic [3:0]  ALU_ADD = 4'b0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result,
  input  logic [3:0]      alu_flags,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] prod_lo,
  output logic [XLEN-1:0] prod_hi
);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  state_t           state_q;
  logic [XLEN-1:0]  hi_q;
  logic [XLEN-1:0]  lo_q;
  logic [XLEN-1:0]  mcand_q;
  logic [XLEN-1:0]  prodLo_q;
  logic [XLEN-1:0]  prodHi_q;
  logic [CNT_W-1:0] count_q;
  logic             busy_q;
  logic             done_q;

  logic [XLEN-1:0]  hi_d;
  logic [XLEN-1:0]  lo_d;
  logic             lastIter;
  logic             unusedFlags;

  // The ALU carry becomes the new top bit of hi so the 65-bit partial sum is never truncated.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = ALU_ADD;
    if (state_q == ITER) begin
      alu_a = hi_q;
      alu_b = lo_q[0] ? mcand_q : '0;
    end
    hi_d        = {alu_flags[2], alu_result[XLEN-1:1]};
    lo_d        = {alu_result[0], lo_q[XLEN-1:1]};
    lastIter    = (count_q == CNT_W'(XLEN - 1));
    unusedFlags = ^{alu_flags[3], alu_flags[1:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      prodLo_q <= '0;
      prodHi_q <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= ITER;
            hi_q    <= '0;
            lo_q    <= op_b;
            mcand_q <= op_a;
            count_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        ITER: begin
          // A flush wins even on the final iteration, leaving the shadow product untouched.
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            count_q <= count_q + CNT_W'(1);
            if (lastIter) begin
              state_q  <= DONE;
              prodHi_q <= hi_d;
              prodLo_q <= lo_d;
              done_q   <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign prod_lo = prodLo_q;
  assign prod_hi = prodHi_q;

endmodule

// File: tb/tb_mul_alu_seq.sv
// Self-checking bench for mul_alu_seq with a behavioural ALU model on the alu_* bus:
// table-driven products plus hand-written ignore/abort/reset/back-to-back sequences.
module tb_mul_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  logic        busy;
  logic        done;
  logic [31:0] prod_lo;
  logic [31:0] prod_hi;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
  } vec_t;

  vec_t vecs[8];

  mul_alu_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .op_a      (op_a),
    .op_b      (op_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ctrl  (alu_ctrl),
    .alu_result(alu_result),
    .alu_flags (alu_flags),
    .busy      (busy),
    .done      (done),
    .prod_lo   (prod_lo),
    .prod_hi   (prod_hi)
  );

  always #5 clk = ~clk;

  // Stand-in for the EX-stage ALU: ADD for code 0000, SUB otherwise, flags {v,c,n,z}.
  always_comb begin
    logic [32:0] sum;
    logic        v;
    if (alu_ctrl == 4'b0000) begin
      sum = {1'b0, alu_a} + {1'b0, alu_b};
      v   = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
    end else begin
      sum = {1'b0, alu_a} - {1'b0, alu_b};
      v   = (alu_a[31] != alu_b[31]) && (sum[31] != alu_a[31]);
    end
    alu_result = sum[31:0];
    alu_flags  = {v, sum[32], sum[31], (sum[31:0] == 32'h0)};
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called at a negedge while IDLE; returns #1 after the accepting edge, i.e. in cycle 1.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    op_a = 32'h5A5A_5A5A;
    op_b = 32'hA5A5_A5A5;
  endtask

  // Waits for done (bounded); optionally pulses start during cycle injectCyc.
  task automatic waitDone(input int injectCyc, output int doneCyc);
    int cyc = 1;
    doneCyc = 0;
    while (cyc <= 40 && doneCyc == 0) begin
      @(negedge clk);
      start = (cyc == injectCyc);
      if (start) begin
        op_a = 32'h0000_0009;
        op_b = 32'h0000_0009;
      end
      if (done) doneCyc = cyc;
      else begin
        @(posedge clk);
        cyc++;
      end
    end
    start = 1'b0;
  endtask

  // Full operation: returns at the negedge of cycle 34, ready for a back-to-back start.
  task automatic runOp(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int injectCyc);
    int doneCyc;
    applyStimulus(a, b);
    waitDone(injectCyc, doneCyc);
    checkOutput({name, "_latency"}, 64'(doneCyc), 64'd33);
    checkOutput({name, "_prod"}, {prod_hi, prod_lo}, exp);
    @(posedge clk);
    @(negedge clk);
    checkOutput({name, "_done_once"}, {63'h0, done}, 64'h0);
    checkOutput({name, "_idle"}, {63'h0, busy}, 64'h0);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000};
    vecs[3] = '{32'h0000_0000, 32'hDEAD_BEEF, 64'h0000_0000_0000_0000};
    vecs[4] = '{32'h0000_0007, 32'hFFFF_FFFF, 64'h0000_0006_FFFF_FFF9};
    vecs[5] = '{32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780};
    vecs[6] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
    vecs[7] = '{32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF};

    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", {63'h0, busy}, 64'h0);
    checkOutput("rst_done", {63'h0, done}, 64'h0);
    checkOutput("rst_prod", {prod_hi, prod_lo}, 64'h0);
    checkOutput("rst_alu_ab", {alu_a, alu_b}, 64'h0);
    checkOutput("rst_alu_ctrl", {60'h0, alu_ctrl}, 64'h0);

    // First iteration drive: hi=0, lo[0]=1 so the multiplicand goes to alu_b.
    applyStimulus(32'h0000_0003, 32'h0000_0005);
    @(negedge clk);
    checkOutput("iter1_busy", {63'h0, busy}, 64'h1);
    checkOutput("iter1_alu_ab", {alu_a, alu_b}, {32'h0, 32'h3});
    checkOutput("iter1_alu_ctrl", {60'h0, alu_ctrl}, 64'h0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("iter2_alu_ab", {alu_a, alu_b}, {32'h1, 32'h0});
    repeat (40) begin
      @(negedge clk);
      if (!busy) break;
    end
    checkOutput("first_prod", {prod_hi, prod_lo}, 64'hF);

    for (int i = 0; i < 8; i++) begin
      runOp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].prod, 0);
    end

    // A start in the middle of an operation must not restart or queue it.
    runOp("ignored_start", 32'h0000_0011, 32'h0000_0013, 64'h0000_0000_0000_0143, 10);
    repeat (40) @(negedge clk);
    checkOutput("ignored_no_run", {63'h0, busy}, 64'h0);
    checkOutput("ignored_prod_hold", {prod_hi, prod_lo}, 64'h0000_0000_0000_0143);

    // Abort mid-run: back to IDLE next cycle, no done, product unchanged.
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (19) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", {63'h0, busy}, 64'h0);
    checkOutput("abort_alu_ab", {alu_a, alu_b}, 64'h0);
    begin
      int sawDone = 0;
      repeat (20) begin
        @(negedge clk);
        if (done) sawDone++;
      end
      checkOutput("abort_no_done", 64'(sawDone), 64'h0);
    end
    checkOutput("abort_prod_hold", {prod_hi, prod_lo}, 64'h0000_0000_0000_0143);

    // Start and abort together in IDLE: start is accepted.
    op_a  = 32'h0000_0006;
    op_b  = 32'h0000_0007;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    begin
      int doneCyc;
      waitDone(0, doneCyc);
      checkOutput("start_abort_latency", 64'(doneCyc), 64'd33);
      checkOutput("start_abort_prod", {prod_hi, prod_lo}, 64'd42);
    end
    @(posedge clk);
    @(negedge clk);

    // Reset at cycle 15 of a run clears everything the next cycle.
    applyStimulus(32'h0000_0100, 32'h0000_0100);
    repeat (14) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy", {63'h0, busy}, 64'h0);
    checkOutput("midrst_done", {63'h0, done}, 64'h0);
    checkOutput("midrst_prod", {prod_hi, prod_lo}, 64'h0);
    checkOutput("midrst_alu_ab", {alu_a, alu_b}, 64'h0);

    runOp("b2b_a", 32'hDEAD_BEEF, 32'h0000_0002, 64'h0000_0001_BD5B_7DDE, 0);
    runOp("b2b_b", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
